// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl: multi-channel SAR ADC scan controller; drives mux select, S/H strobe and DAC trial code, tags results by channel.
// Latency: start accepted in T -> valid_o in T+SampleCycles+Width+1; with `define SAR_AVG_EN, 2^AvgLog2*(SampleCycles+Width)+1 per channel.
// Backpressure: none; valid_o/eos_o are single-cycle pulses and result_o holds until the next valid_o.
module sar_scan_ctrl #(
    parameter int Width        = 8,
    parameter int Channels     = 4,
    parameter int SampleCycles = 2,
    parameter int AvgLog2      = 2,
    localparam int CW          = (Channels > 1) ? $clog2(Channels) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                cont_i,
    input  logic [Channels-1:0] ch_mask_i,
    input  logic                cmp_i,
    output logic [Width-1:0]    dac_o,
    output logic                sample_o,
    output logic [CW-1:0]       ch_o,
    output logic                busy_o,
    output logic [Width-1:0]    result_o,
    output logic [CW-1:0]       result_ch_o,
    output logic                valid_o,
    output logic                eos_o
);
    localparam int BW = $clog2(Width);
    localparam int SW = (SampleCycles > 1) ? $clog2(SampleCycles) : 1;
    localparam logic [SW-1:0] SMP_LAST = SW'(SampleCycles - 1);
    localparam logic [BW-1:0] BIT_MSB  = BW'(Width - 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, STORE} state_t;

    state_t              state;
    logic [Channels-1:0] mask;
    logic [SW-1:0]       smp_cnt;
    logic [BW-1:0]       bit_idx;
    logic [Width-1:0]    trial_bit;
    logic [Width-1:0]    sar_next;
    logic [Width-1:0]    conv_result;
    logic                last_pass;
    logic [CW-1:0]       start_ch;
    logic [CW-1:0]       wrap_ch;
    logic [CW-1:0]       nxt_ch;
    logic                nxt_found;

    // Channel sequencing: lowest bit of the incoming mask, lowest latched bit, next latched bit above ch_o
    always_comb begin
        start_ch  = '0;
        wrap_ch   = '0;
        nxt_ch    = '0;
        nxt_found = 1'b0;
        for (int i = Channels - 1; i >= 0; i--) begin
            if (ch_mask_i[i]) start_ch = CW'(i);
            if (mask[i]) wrap_ch = CW'(i);
            if (mask[i] && (i > int'(ch_o))) begin
                nxt_ch    = CW'(i);
                nxt_found = 1'b1;
            end
        end
    end

    // Binary search step: dac_o holds decided bits plus the current trial bit
    always_comb begin
        trial_bit = Width'(1) << bit_idx;
        sar_next  = cmp_i ? dac_o : (dac_o & ~trial_bit);
    end

`ifdef SAR_AVG_EN
    localparam int PW = (AvgLog2 > 0) ? AvgLog2 : 1;
    localparam int AW = Width + AvgLog2;
    localparam logic [PW-1:0] PASS_LAST = PW'((1 << AvgLog2) - 1);

    logic [PW-1:0] pass;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;

    // Running sum including the pass just finishing; result is the truncated mean
    always_comb begin
        acc_sum     = acc + AW'(sar_next);
        conv_result = Width'(acc_sum >> AvgLog2);
        last_pass   = (pass == PASS_LAST);
    end

    // Pass counter and accumulator advance at the last bit of each conversion, cleared per channel
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pass <= '0;
            acc  <= '0;
        end else if (state == CONVERT && bit_idx == '0) begin
            if (last_pass) begin
                pass <= '0;
                acc  <= '0;
            end else begin
                pass <= pass + 1'b1;
                acc  <= acc_sum;
            end
        end
    end
`else
    // Single conversion per channel: the SAR outcome is the result
    always_comb begin
        conv_result = sar_next;
        last_pass   = 1'b1;
    end
`endif

    // Scan FSM with registered outputs; outputs reflect the state they are entered with
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            mask        <= '0;
            smp_cnt     <= '0;
            bit_idx     <= '0;
            dac_o       <= '0;
            sample_o    <= 1'b0;
            ch_o        <= '0;
            busy_o      <= 1'b0;
            result_o    <= '0;
            result_ch_o <= '0;
            valid_o     <= 1'b0;
            eos_o       <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            eos_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && (|ch_mask_i)) begin
                        mask     <= ch_mask_i;
                        ch_o     <= start_ch;
                        busy_o   <= 1'b1;
                        sample_o <= 1'b1;
                        dac_o    <= '0;
                        smp_cnt  <= '0;
                        state    <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (smp_cnt == SMP_LAST) begin
                        sample_o <= 1'b0;
                        dac_o    <= Width'(1) << BIT_MSB;
                        bit_idx  <= BIT_MSB;
                        state    <= CONVERT;
                    end else begin
                        smp_cnt <= smp_cnt + 1'b1;
                    end
                end
                CONVERT: begin
                    if (bit_idx != '0) begin
                        dac_o   <= sar_next | (trial_bit >> 1);
                        bit_idx <= bit_idx - 1'b1;
                    end else if (!last_pass) begin
                        // another averaging pass on the same channel, no gap
                        sample_o <= 1'b1;
                        dac_o    <= '0;
                        smp_cnt  <= '0;
                        state    <= SAMPLE;
                    end else begin
                        result_o    <= conv_result;
                        result_ch_o <= ch_o;
                        valid_o     <= 1'b1;
                        eos_o       <= ~nxt_found;
                        dac_o       <= '0;
                        state       <= STORE;
                    end
                end
                STORE: begin
                    if (nxt_found || cont_i) begin
                        ch_o     <= nxt_found ? nxt_ch : wrap_ch;
                        sample_o <= 1'b1;
                        smp_cnt  <= '0;
                        state    <= SAMPLE;
                    end else begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sar_scan_ctrl.sv
// tb_sar_scan_ctrl: scoreboard bench for sar_scan_ctrl with a per-channel comparator model.
// Latency: expected valid_o cycle is pushed with each expected result and compared on arrival.
// Backpressure: none; SAR_AVG_EN selects the averaged per-channel period and the averaging scenario.
module tb_sar_scan_ctrl;
    localparam int W = 8;
    localparam int N = 4;
    localparam int S = 2;
    localparam int A = 2;
`ifdef SAR_AVG_EN
    localparam int PER = (1 << A) * (S + W) + 1;
`else
    localparam int PER = S + W + 1;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic         cont_i = 1'b0;
    logic [N-1:0] ch_mask_i = '0;
    logic         cmp_i;
    logic [W-1:0] dac_o;
    logic         sample_o;
    logic [1:0]   ch_o;
    logic         busy_o;
    logic [W-1:0] result_o;
    logic [1:0]   result_ch_o;
    logic         valid_o;
    logic         eos_o;

    logic [W-1:0] vin [N];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int valid_cnt = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [1:0]   ch;
        logic         eos;
        int           at;
    } exp_t;
    exp_t sb[$];

    sar_scan_ctrl #(.Width(W), .Channels(N), .SampleCycles(S), .AvgLog2(A)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cont_i(cont_i),
        .ch_mask_i(ch_mask_i), .cmp_i(cmp_i), .dac_o(dac_o), .sample_o(sample_o),
        .ch_o(ch_o), .busy_o(busy_o), .result_o(result_o), .result_ch_o(result_ch_o),
        .valid_o(valid_o), .eos_o(eos_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Comparator front-end: Vin of the selected channel against the DAC code
    assign cmp_i = (vin[ch_o] >= dac_o);

    // Result monitor: every valid_o must match the oldest expected entry, including its cycle
    always @(negedge clk_i) begin : mon
        exp_t e;
        if (valid_o) begin
            valid_cnt++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: result=%h ch=%0d eos=%0d at cycle %0d, required no valid_o",
                         result_o, result_ch_o, eos_o, cyc);
            end else begin
                e = sb.pop_front();
                if ({result_o, result_ch_o, eos_o} !== {e.res, e.ch, e.eos} || cyc != e.at) begin
                    failures++;
                    $display("FAIL result: got res=%h ch=%0d eos=%0d cyc=%0d, required res=%h ch=%0d eos=%0d cyc=%0d",
                             result_o, result_ch_o, eos_o, cyc, e.res, e.ch, e.eos, e.at);
                end
            end
        end
    end

    task automatic push(input logic [W-1:0] r, input logic [1:0] c, input logic eo, input int at);
        exp_t e;
        e.res = r; e.ch = c; e.eos = eo; e.at = at;
        sb.push_back(e);
    endtask

    // Pulse start_i for one cycle; t is the cycle in which it is sampled
    task automatic do_start(input logic [N-1:0] m, output int t);
        @(negedge clk_i);
        ch_mask_i = m;
        start_i = 1'b1;
        t = cyc;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: %0d results pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) @(negedge clk_i);
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({dac_o, sample_o, ch_o, busy_o, result_o, result_ch_o, valid_o, eos_o} !== '0) begin
            failures++;
            $display("FAIL reset_values: outputs=%h, required 0",
                     {dac_o, sample_o, ch_o, busy_o, result_o, result_ch_o, valid_o, eos_o});
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_single;
        int t;
        logic [W-1:0] exp_dac [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        vin[0] = 8'hA5;
        do_start(4'b0001, t);
        push(8'hA5, 2'd0, 1'b1, t + PER);
        checks++;
        if ({sample_o, dac_o, ch_o, busy_o} !== {1'b1, 8'h00, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL single_sample: sample=%0d dac=%h ch=%0d busy=%0d, required 1 00 0 1",
                     sample_o, dac_o, ch_o, busy_o);
        end
        wait_cycle(t + S + 1);
        for (int i = 0; i < W; i++) begin
            checks++;
            if (dac_o !== exp_dac[i] || sample_o !== 1'b0) begin
                failures++;
                $display("FAIL single_dac%0d: dac=%h sample=%0d, required %h 0", i, dac_o, sample_o, exp_dac[i]);
            end
            @(negedge clk_i);
        end
        wait_drain(PER + 5, "single");
        wait_cycle(t + PER + 1);
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: busy=%0d, required 0", busy_o);
        end
    endtask

    task automatic test_reset_mid;
        int t;
        int vc;
        vin[2] = 8'h33;
        vc = valid_cnt;
        do_start(4'b0100, t);
        wait_cycle(t + S + 3);
        checks++;
        if (busy_o !== 1'b1 || ch_o !== 2'd2) begin
            failures++;
            $display("FAIL midreset_busy: busy=%0d ch=%0d, required 1 2", busy_o, ch_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if ({dac_o, sample_o, ch_o, busy_o, result_o, result_ch_o, valid_o, eos_o} !== '0) begin
            failures++;
            $display("FAIL midreset_values: outputs=%h, required 0",
                     {dac_o, sample_o, ch_o, busy_o, result_o, result_ch_o, valid_o, eos_o});
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (PER + 10) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || valid_cnt != vc) begin
            failures++;
            $display("FAIL midreset_after: busy=%0d valids=%0d, required 0 %0d", busy_o, valid_cnt, vc);
        end
    endtask

    task automatic test_sparse;
        int t;
        logic bad = 1'b0;
        vin[1] = 8'h3C;
        vin[3] = 8'hFF;
        do_start(4'b1010, t);
        push(8'h3C, 2'd1, 1'b0, t + PER);
        push(8'hFF, 2'd3, 1'b1, t + 2 * PER);
        while (cyc <= t + 2 * PER) begin
            if (busy_o && (ch_o == 2'd0 || ch_o == 2'd2)) bad = 1'b1;
            @(negedge clk_i);
        end
        wait_drain(5, "sparse");
        checks++;
        if (bad !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL sparse_ch: skipped channel selected=%0d busy=%0d, required 0 0", bad, busy_o);
        end
    endtask

    task automatic test_cont;
        int t;
        vin[0] = 8'h55;
        vin[1] = 8'hAA;
        cont_i = 1'b1;
        do_start(4'b0011, t);
        for (int s = 0; s < 3; s++) begin
            push(8'h55, 2'd0, 1'b0, t + (2 * s + 1) * PER);
            push(8'hAA, 2'd1, 1'b1, t + (2 * s + 2) * PER);
        end
        while (cyc < t + 6 * PER + 1) begin
            if (cyc == t + PER + 4) begin
                start_i = 1'b1;
                ch_mask_i = 4'b1100;
            end else if (cyc == t + 3 * PER - 3) begin
                start_i = 1'b1;
                ch_mask_i = 4'b1111;
            end else begin
                start_i = 1'b0;
            end
            if (cyc == t + 5 * PER + 2) cont_i = 1'b0;
            @(negedge clk_i);
        end
        start_i = 1'b0;
        ch_mask_i = '0;
        wait_drain(5, "cont");
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL cont_stop: busy=%0d, required 0", busy_o);
        end
    endtask

    task automatic test_edges;
        int t;
        int t2;
        logic stray = 1'b0;
        vin[0] = 8'h00;
        do_start(4'b0001, t);
        push(8'h00, 2'd0, 1'b1, t + PER);
        wait_cycle(t + PER + 1);
        vin[0] = 8'hFF;
        ch_mask_i = 4'b0001;
        start_i = 1'b1;
        t2 = cyc;
        @(negedge clk_i);
        start_i = 1'b0;
        push(8'hFF, 2'd0, 1'b1, t2 + PER);
        wait_drain(PER + 5, "edges");
        wait_cycle(t2 + PER + 1);
        do_start(4'b0000, t);
        repeat (5) begin
            if (busy_o !== 1'b0) stray = 1'b1;
            @(negedge clk_i);
        end
        checks++;
        if (stray !== 1'b0) begin
            failures++;
            $display("FAIL empty_mask: busy seen=%0d, required 0", stray);
        end
    endtask

`ifdef SAR_AVG_EN
    task automatic test_avg;
        int t;
        logic prev = 1'b1;
        vin[0] = 8'h10;
        do_start(4'b0001, t);
        push(8'h11, 2'd0, 1'b1, t + PER);
        while (cyc <= t + PER) begin
            if (sample_o && !prev) vin[0] = vin[0] + 8'h01;
            prev = sample_o;
            @(negedge clk_i);
        end
        wait_drain(5, "avg");
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) vin[i] = '0;
        test_reset;
        test_single;
        test_reset_mid;
        test_sparse;
        test_cont;
        test_edges;
`ifdef SAR_AVG_EN
        test_avg;
`endif
        repeat (3) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
